// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions: opcodes, write-data select encodings,
// the reset PC and the M/W pipeline register layout.
package writeback_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_LUI = 6'b001111;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_DM  = 2'd1,
    WD_PC8 = 2'd2,
    WD_LUI = 2'd3
  } wd_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] dm_out;
    logic [31:0] shift;
    logic [4:0]  reg_wreg;
    logic        reg_write;
    wd_sel_e     memtoreg;
    logic        valid;
  } mw_reg_t;

  // Link address written by jal: the instruction after the delay slot.
  function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// M-to-W bus: instruction state leaving Memory and the W-stage results.
// master drives the M side (upstream stage / bench), slave is the W stage.
interface writeback_stage_if;
  logic [31:0] in_PC;
  logic [31:0] in_instruction;
  logic [31:0] in_ALUout;
  logic [31:0] in_DMout;
  logic [31:0] in_Shift;
  logic [4:0]  in_RegWreg;
  logic        in_RegWrite;
  logic [1:0]  in_MemtoReg;
  logic        in_valid;
  logic        flush;
  logic [31:0] out_PC;
  logic [31:0] out_instruction;
  logic [4:0]  W_RegWreg;
  logic        W_RegWrite;
  logic [31:0] W_WD;
  logic [1:0]  W_Tnew;
  logic        W_valid;
  logic [31:0] retire_cnt;

  modport master (
    output in_PC, in_instruction, in_ALUout, in_DMout, in_Shift,
           in_RegWreg, in_RegWrite, in_MemtoReg, in_valid, flush,
    input  out_PC, out_instruction, W_RegWreg, W_RegWrite, W_WD,
           W_Tnew, W_valid, retire_cnt
  );

  modport slave (
    input  in_PC, in_instruction, in_ALUout, in_DMout, in_Shift,
           in_RegWreg, in_RegWrite, in_MemtoReg, in_valid, flush,
    output out_PC, out_instruction, W_RegWreg, W_RegWrite, W_WD,
           W_Tnew, W_valid, retire_cnt
  );
endinterface

// File: rtl/writeback_stage_load_ext.sv
// Load data extension: picks the byte/halfword addressed by the low
// address bits (little-endian) and sign- or zero-extends it by opcode.
module writeback_stage_load_ext
  import writeback_stage_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte lane and halfword lane selection from the address offset.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (off)
      2'd0:    byte_s = raw[7:0];
      2'd1:    byte_s = raw[15:8];
      2'd2:    byte_s = raw[23:16];
      2'd3:    byte_s = raw[31:24];
      default: byte_s = 8'h00;
    endcase
    // Halfword loads ignore off[0]; misalignment is trapped upstream.
    if (off[1]) begin
      half_s = raw[31:16];
    end else begin
      half_s = raw[15:0];
    end
  end

  // Extension by load opcode; anything else passes the raw word through.
  always_comb begin
    data = raw;
    case (opcode)
      OP_LW:   data = raw;
      OP_LB:   data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  data = {24'h00_0000, byte_s};
      OP_LH:   data = {{16{half_s[15]}}, half_s};
      OP_LHU:  data = {16'h0000, half_s};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: M/W pipeline register, load extension, register-file
// write-data select and a retired-instruction counter for trace compare.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  writeback_stage_if.slave wb
);

  mw_reg_t     mw_r;
  logic [31:0] retire_cnt_r;
  logic        bubble_s;
  logic [31:0] load_data_s;
  logic [31:0] wd_s;

  assign bubble_s = wb.flush | ~wb.in_valid;

  // M/W register and retire counter; bubbles keep the PC but drop all effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mw_r.pc        <= RESET_PC;
      mw_r.instr     <= 32'h0000_0000;
      mw_r.alu_out   <= 32'h0000_0000;
      mw_r.dm_out    <= 32'h0000_0000;
      mw_r.shift     <= 32'h0000_0000;
      mw_r.reg_wreg  <= 5'd0;
      mw_r.reg_write <= 1'b0;
      mw_r.memtoreg  <= WD_ALU;
      mw_r.valid     <= 1'b0;
      retire_cnt_r   <= 32'h0000_0000;
    end else begin
      mw_r.pc      <= wb.in_PC;
      mw_r.alu_out <= wb.in_ALUout;
      mw_r.dm_out  <= wb.in_DMout;
      mw_r.shift   <= wb.in_Shift;
      if (bubble_s) begin
        mw_r.instr     <= 32'h0000_0000;
        mw_r.reg_wreg  <= 5'd0;
        mw_r.reg_write <= 1'b0;
        mw_r.memtoreg  <= WD_ALU;
        mw_r.valid     <= 1'b0;
        retire_cnt_r   <= retire_cnt_r;
      end else begin
        mw_r.instr     <= wb.in_instruction;
        mw_r.reg_wreg  <= wb.in_RegWreg;
        // $0 is hardwired; never let a write to it reach the register file.
        mw_r.reg_write <= wb.in_RegWrite & (wb.in_RegWreg != 5'd0);
        mw_r.memtoreg  <= wd_sel_e'(wb.in_MemtoReg);
        mw_r.valid     <= 1'b1;
        retire_cnt_r   <= retire_cnt_r + 32'd1;
      end
    end
  end

  writeback_stage_load_ext u_load_ext (
    .opcode (mw_r.instr[31:26]),
    .off    (mw_r.alu_out[1:0]),
    .raw    (mw_r.dm_out),
    .data   (load_data_s)
  );

  // Register-file write data; combinational from the register so it is
  // available as the W forwarding value in the same cycle.
  always_comb begin
    wd_s = mw_r.alu_out;
    case (mw_r.memtoreg)
      WD_ALU:  wd_s = mw_r.alu_out;
      WD_DM:   wd_s = load_data_s;
      WD_PC8:  wd_s = pc_plus8(mw_r.pc);
      WD_LUI:  wd_s = mw_r.shift;
      default: wd_s = mw_r.alu_out;
    endcase
  end

  assign wb.out_PC          = mw_r.pc;
  assign wb.out_instruction = mw_r.instr;
  assign wb.W_RegWreg       = mw_r.reg_wreg;
  assign wb.W_RegWrite      = mw_r.reg_write;
  assign wb.W_WD            = wd_s;
  assign wb.W_Tnew          = 2'd0;
  assign wb.W_valid         = mw_r.valid;
  assign wb.retire_cnt      = retire_cnt_r;

endmodule
